// File: rtl/plab4_net_router_domain_sched_tp.sv
// -----------------------------------------------------------------------------
// plab4_net_router_domain_sched_tp
//
// Time-division domain scheduler for the timing-channel-protected router.
// It produces the domain0/domain1 select pair used by the router input control
// arbiter. The schedule is fixed and non-work-conserving: slot lengths are
// compile-time constants and never depend on traffic.
//
// Configuration macro: PLAB4_NET_DOMAIN_SCHED_DEAD_EN
//   defined   : D0 -> DEAD0 -> D1 -> DEAD1 -> D0, with p_dead_cycles idle
//               cycles after each slot so that in-flight flits can drain.
//   undefined : D0 -> D1 -> D0, and p_dead_cycles is ignored.
//
// Parameters
//   p_slot_cycles_d0 : cycles domain 0 is active per period (>= 1)
//   p_slot_cycles_d1 : cycles domain 1 is active per period (>= 1)
//   p_dead_cycles    : idle cycles after each slot (>= 1)
//
// Ports
//   clk         in   clock; all state updates on the rising edge
//   reset       in   asynchronous active-high reset
//   sched_en    in   1 = schedule advances, 0 = state and counter freeze
//   domain0     out  registered; 1 while domain 0 owns the router
//   domain1     out  registered; 1 while domain 1 owns the router
//   epoch_start out  registered; 1 on the first cycle of each D0 slot
// -----------------------------------------------------------------------------
module plab4_net_router_domain_sched_tp #(
   parameter int p_slot_cycles_d0 = 16,
   parameter int p_slot_cycles_d1 = 16,
   parameter int p_dead_cycles    = 2
) (
   input  logic clk,
   input  logic reset,
   input  logic sched_en,
   output logic domain0,
   output logic domain1,
   output logic epoch_start
);

   localparam int c_max01     = (p_slot_cycles_d0 > p_slot_cycles_d1) ?
                                p_slot_cycles_d0 : p_slot_cycles_d1;
   localparam int c_max       = (c_max01 > p_dead_cycles) ? c_max01 : p_dead_cycles;
   localparam int c_cnt_nbits = $clog2(c_max) + 1;

   typedef logic [c_cnt_nbits-1:0] cnt_t;

   // Counter reload values: a state of length N counts N-1 down to 0.
   localparam cnt_t c_load_d0   = cnt_t'(p_slot_cycles_d0 - 1);
   localparam cnt_t c_load_d1   = cnt_t'(p_slot_cycles_d1 - 1);
   localparam cnt_t c_load_dead = cnt_t'(p_dead_cycles - 1);
   localparam cnt_t c_zero      = cnt_t'(0);
   localparam cnt_t c_one       = cnt_t'(1);

   typedef enum logic [1:0] {
      D0    = 2'd0,
      DEAD0 = 2'd1,
      D1    = 2'd2,
      DEAD1 = 2'd3
   } state_t;

   state_t state;
   cnt_t   cnt;
   state_t nxt;

   // Fixed rotation order; the dead states exist only when compiled in.
   function automatic state_t next_state(input state_t s);
      state_t n;
`ifdef PLAB4_NET_DOMAIN_SCHED_DEAD_EN
      case (s)
         D0:      n = DEAD0;
         DEAD0:   n = D1;
         D1:      n = DEAD1;
         DEAD1:   n = D0;
         default: n = D0;
      endcase
`else
      case (s)
         D0:      n = D1;
         D1:      n = D0;
         default: n = D0;
      endcase
`endif
      return n;
   endfunction

   // Length-minus-one of the state being entered.
   function automatic cnt_t load_for(input state_t s);
      cnt_t v;
      case (s)
         D0:      v = c_load_d0;
         D1:      v = c_load_d1;
         DEAD0:   v = c_load_dead;
         DEAD1:   v = c_load_dead;
         default: v = c_load_d0;
      endcase
      return v;
   endfunction

   // Successor of the current state, used only on the slot-ending edge.
   always_comb begin
      nxt = D0;
      nxt = next_state(state);
   end

   // Schedule FSM, slot counter and registered outputs.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state       <= D0;
         cnt         <= c_load_d0;
         domain0     <= 1'b1;
         domain1     <= 1'b0;
         epoch_start <= 1'b1;
      end else if (sched_en) begin
         if (cnt == c_zero) begin
            // Slot over: enter the next state and derive its outputs from
            // the entered state so they stay aligned with it.
            state       <= nxt;
            cnt         <= load_for(nxt);
            domain0     <= (nxt == D0);
            domain1     <= (nxt == D1);
            epoch_start <= (nxt == D0);
         end else begin
            cnt         <= cnt - c_one;
            epoch_start <= 1'b0;
         end
      end else begin
         // Frozen: every register, including epoch_start, holds.
         state       <= state;
         cnt         <= cnt;
         domain0     <= domain0;
         domain1     <= domain1;
         epoch_start <= epoch_start;
      end
   end

endmodule

// File: tb/tb_plab4_net_router_domain_sched_tp.sv
// -----------------------------------------------------------------------------
// Testbench for plab4_net_router_domain_sched_tp.
// Three instances (defaults, asymmetric 3/5/1, all ones) share clock, reset
// and sched_en. The reference model maps the number of enabled edges since
// reset onto a position inside the schedule period with plain arithmetic.
// -----------------------------------------------------------------------------
module tb_plab4_net_router_domain_sched_tp;

`ifdef PLAB4_NET_DOMAIN_SCHED_DEAD_EN
   localparam bit c_dead_en = 1'b1;
`else
   localparam bit c_dead_en = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic en  = 1'b0;

   logic def_d0, def_d1, def_ep;
   logic asy_d0, asy_d1, asy_ep;
   logic one_d0, one_d1, one_ep;

   int n_tests = 0;
   int n_fail  = 0;
   int n_edges = 0;   // enabled clock edges since reset released

   always #5 clk = ~clk;

   plab4_net_router_domain_sched_tp u_def (
      .clk(clk), .reset(rst), .sched_en(en),
      .domain0(def_d0), .domain1(def_d1), .epoch_start(def_ep));

   plab4_net_router_domain_sched_tp #(
      .p_slot_cycles_d0(3), .p_slot_cycles_d1(5), .p_dead_cycles(1)
   ) u_asy (
      .clk(clk), .reset(rst), .sched_en(en),
      .domain0(asy_d0), .domain1(asy_d1), .epoch_start(asy_ep));

   plab4_net_router_domain_sched_tp #(
      .p_slot_cycles_d0(1), .p_slot_cycles_d1(1), .p_dead_cycles(1)
   ) u_one (
      .clk(clk), .reset(rst), .sched_en(en),
      .domain0(one_d0), .domain1(one_d1), .epoch_start(one_ep));

   typedef struct {
      int   cyc;
      logic d0;
      logic d1;
      logic ep;
   } vec_t;

   vec_t tbl[$];

   // Expected {domain0, domain1, epoch_start} after n enabled edges.
   function automatic logic [2:0] model(input int n, input int a, input int b, input int dd);
      int dead;
      int per;
      int p;
      logic e0, e1, ep;
      dead = c_dead_en ? dd : 0;
      per  = a + b + 2 * dead;
      p    = n % per;
      e0   = (p < a) ? 1'b1 : 1'b0;
      e1   = ((p >= a + dead) && (p < a + dead + b)) ? 1'b1 : 1'b0;
      ep   = (p == 0) ? 1'b1 : 1'b0;
      return {e0, e1, ep};
   endfunction

   task automatic check(input string name, input logic [2:0] got, input logic [2:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %b expected %b (edges=%0d, t=%0t)", name, got, exp, n_edges, $time);
      end
   endtask

   task automatic check_all(input string tag);
      check({tag, "/def"}, {def_d0, def_d1, def_ep}, model(n_edges, 16, 16, 2));
      check({tag, "/asy"}, {asy_d0, asy_d1, asy_ep}, model(n_edges, 3, 5, 1));
      check({tag, "/one"}, {one_d0, one_d1, one_ep}, model(n_edges, 1, 1, 1));
      check({tag, "/excl"}, {1'b0, 1'b0, (def_d0 & def_d1) | (asy_d0 & asy_d1) | (one_d0 & one_d1)},
            3'b000);
   endtask

   // One clock: count the edge if it was enabled, return at the next negedge.
   task automatic tick();
      @(posedge clk);
      if (!rst && en) n_edges++;
      @(negedge clk);
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1;
      en  = 1'b1;
      #1;
      check("reset/def", {def_d0, def_d1, def_ep}, 3'b101);
      check("reset/asy", {asy_d0, asy_d1, asy_ep}, 3'b101);
      check("reset/one", {one_d0, one_d1, one_ep}, 3'b101);
      @(negedge clk);
      rst     = 1'b0;
      n_edges = 0;
   endtask

   initial begin
`ifdef PLAB4_NET_DOMAIN_SCHED_DEAD_EN
      tbl.push_back('{0, 1'b1, 1'b0, 1'b1});
      tbl.push_back('{15, 1'b1, 1'b0, 1'b0});
      tbl.push_back('{16, 1'b0, 1'b0, 1'b0});
      tbl.push_back('{17, 1'b0, 1'b0, 1'b0});
      tbl.push_back('{18, 1'b0, 1'b1, 1'b0});
      tbl.push_back('{33, 1'b0, 1'b1, 1'b0});
      tbl.push_back('{34, 1'b0, 1'b0, 1'b0});
      tbl.push_back('{35, 1'b0, 1'b0, 1'b0});
      tbl.push_back('{36, 1'b1, 1'b0, 1'b1});
      tbl.push_back('{37, 1'b1, 1'b0, 1'b0});
`else
      tbl.push_back('{0, 1'b1, 1'b0, 1'b1});
      tbl.push_back('{15, 1'b1, 1'b0, 1'b0});
      tbl.push_back('{16, 1'b0, 1'b1, 1'b0});
      tbl.push_back('{31, 1'b0, 1'b1, 1'b0});
      tbl.push_back('{32, 1'b1, 1'b0, 1'b1});
      tbl.push_back('{33, 1'b1, 1'b0, 1'b0});
`endif

      // Directed default schedule against the table, plus the model each cycle.
      do_reset();
      for (int c = 0; c <= 40; c++) begin
         foreach (tbl[i]) begin
            if (tbl[i].cyc == c)
               check($sformatf("table/c%0d", c), {def_d0, def_d1, def_ep},
                     {tbl[i].d0, tbl[i].d1, tbl[i].ep});
         end
         check_all("sweep");
         tick();
      end

      // sched_en dropped for 7 cycles at cycle 10 of D0.
      do_reset();
      for (int w = 0; w <= 45; w++) begin
         check_all("freeze");
         if (w == 22) check("freeze/d0_hold", {2'b00, def_d0}, 3'b001);
         if (w == 23) check("freeze/d0_fall", {2'b00, def_d0}, 3'b000);
         if (w == (c_dead_en ? 43 : 39))
            check("freeze/period", {2'b00, def_ep}, 3'b001);
         en = (w >= 10 && w < 17) ? 1'b0 : 1'b1;
         tick();
      end

      // Frozen on the first D0 cycle: epoch_start must stay high.
      do_reset();
      en = 1'b0;
      for (int w = 0; w < 4; w++) tick();
      check("freeze/epoch_hold", {def_d0, def_d1, def_ep}, 3'b101);
      en = 1'b1;

      // Asynchronous reset between edges while domain 1 owns the router.
      do_reset();
      for (int w = 0; w < 20; w++) tick();
      check("async/pre_d1", {def_d0, def_d1, 1'b0}, 3'b010);
      #2;
      rst = 1'b1;
      #1;
      check("async/immediate", {def_d0, def_d1, def_ep}, 3'b101);
      n_edges = 0;
      @(negedge clk);
      rst = 1'b0;
      for (int w = 0; w < 40; w++) begin
         check_all("restart");
         tick();
      end

      // Randomized enable pattern with occasional resets.
      do_reset();
      for (int k = 0; k < 3000; k++) begin
         check_all("rand");
         if ($urandom_range(0, 299) == 0) begin
            do_reset();
         end else begin
            en = ($urandom_range(0, 3) != 0) ? 1'b1 : 1'b0;
            tick();
         end
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/plab4_net_router_domain_sched_tp.md
# plab4_net_router_domain_sched_tp

Time-division domain scheduler for the timing-channel-protected router. It generates the `domain0`/`domain1` select pair that the router input control arbiter uses to pick which security domain's requests reach the switch allocator. The schedule is fixed and non-work-conserving: slot lengths never depend on traffic, so one domain's activity cannot change when the other is served. Optional dead cycles between slots let in-flight flits of the outgoing domain drain before the incoming domain is enabled.

## Interface
- `p_slot_cycles_d0`, default 16: cycles domain 0 is active per period; ≥1.
- `p_slot_cycles_d1`, default 16: cycles domain 1 is active per period; ≥1.
- `p_dead_cycles`, default 2: idle cycles after each slot; ≥1; used only when dead cycles are compiled in.
- `c_cnt_nbits`, derived: `$clog2(max(p_slot_cycles_d0, p_slot_cycles_d1, p_dead_cycles)) + 1`; not set externally.
- `clk`  input  1  clock; all state updates on the rising edge.
- `reset`  input  1  asynchronous, active-high reset.
- `sched_en`  input  1  when 1 the schedule advances; when 0 the state and counter freeze.
- `domain0`  output  1  registered; 1 while domain 0 owns the router.
- `domain1`  output  1  registered; 1 while domain 1 owns the router.
- `epoch_start`  output  1  registered; 1-cycle pulse on the first cycle of each D0 slot.

## Operation
- FSM states: D0, DEAD0, D1, DEAD1. Down-counter `cnt` of width `c_cnt_nbits` counts the cycles remaining in the current state.
- Outputs are pure functions of registered state:
  - D0: `domain0`=1.
  - D1: `domain1`=1.
  - DEAD0 and DEAD1: both outputs 0.
  - `domain0` and `domain1` are never both 1.
- On entry to a state, `cnt` loads that state's length minus 1. The state is left on the enabled edge where `cnt`==0.
- Transition order: D0→DEAD0→D1→DEAD1→D0.
- `epoch_start` is 1 during the first cycle of D0, which is the cycle after a DEAD1→D0 transition. It also asserts in the first cycle after reset is released.
- `sched_en`=0: `cnt`, state and all outputs hold their current values. `epoch_start` stays high if frozen on the first D0 cycle. Resuming continues exactly where the schedule stopped.
- Reset, asserted at any time including mid-slot:
  - takes effect immediately (asynchronous);
  - state=D0, `cnt`=`p_slot_cycles_d0`-1;
  - `domain0`=1, `domain1`=0, `epoch_start`=1.
- Parameters equal to 1 give a single-cycle state with no special casing. The counter never wraps below 0.

## Timing
- Output latency: 0 cycles from state, because outputs are registered with the state.
- Schedule period = `p_slot_cycles_d0` + `p_slot_cycles_d1` + 2·`p_dead_cycles` enabled cycles. With defaults, the period is 36.
- The schedule is independent of every router signal except `sched_en` and `reset`.

## Configuration
- `PLAB4_NET_DOMAIN_SCHED_DEAD_EN` defined:
  - DEAD0 and DEAD1 are present as described above.
- Not defined:
  - DEAD0 and DEAD1 are removed, and the transitions become D0→D1→D0.
  - `p_dead_cycles` is ignored.
  - Period = `p_slot_cycles_d0` + `p_slot_cycles_d1`.
  - `domain1` rises on the same edge that `domain0` falls.

## Test plan
- Reset release, defaults, macro defined, `sched_en`=1 →
  - `domain0`=1 for cycles 0–15;
  - both 0 for cycles 16–17;
  - `domain1`=1 for cycles 18–33;
  - both 0 for cycles 34–35;
  - `epoch_start` pulses at cycles 0 and 36.
- Asymmetric slots (d0=3, d1=5, dead=1) → the pattern repeats every 10 cycles: 3×D0, 1 idle, 5×D1, 1 idle.
- `sched_en` dropped for 7 cycles at cycle 10 of D0 → outputs hold; `domain0` falls at cycle 23 instead of 16; the full period is 43.
- `reset` asserted at cycle 20 (inside D1), between clock edges → `domain1`→0 and `domain0`→1 immediately without waiting for a clock edge; `epoch_start`=1; the schedule restarts from cycle 0.
- Macro undefined, defaults → `domain0` for cycles 0–15, `domain1` for cycles 16–31, period 32, never both 0.
- All parameters = 1, macro defined → the sequence D0, idle, D1, idle repeats with period 4; every cycle the check `domain0 & domain1`==0 holds.
